ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 20 ++
 rtl/ccff_crc16.sv | 21 ++
 rtl/ccff_loader.sv | 133 +++++++++++++
 tb/tb_ccff_loader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared state enum, CRC-16 constants and serial CRC step for the ccff loader
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } ccff_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// rtl/ccff_crc16.sv - serial bit-in CRC-16 with synchronous clear and enable
module ccff_crc16
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - streams a bitstream into the fabric ccff chain, then recirculates it to verify by CRC
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 128,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_ok,
  output logic              err
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BUF_CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [BUF_CNT_W-1:0] BUF_ONE   = BUF_CNT_W'(1);
  localparam logic [BUF_CNT_W-1:0] BUF_FULL  = BUF_CNT_W'(WORD_W);

  ccff_state_t          state;
  logic [CNT_W-1:0]     shift_cnt;
  logic [WORD_W-1:0]    buf_data;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [15:0]          crc_ld;
  logic [15:0]          crc_rb;
  logic                 load_shift;
  logic                 verify_shift;
  logic                 final_bit;
  logic                 accept;
  logic                 crc_clr;

  always_comb begin
    load_shift   = (state == ST_LOAD) && (buf_cnt != '0);
    verify_shift = (state == ST_VERIFY);
    final_bit    = (shift_cnt == LAST_CNT);
    // No new word is taken on the cycle that shifts the chain's last bit.
    s_ready      = (state == ST_LOAD) && (buf_cnt <= BUF_ONE) && !(load_shift && final_bit);
    accept       = s_valid && s_ready;
    prog_en      = load_shift || verify_shift;
    crc_clr      = (state == ST_IDLE) && start;
    case (state)
      ST_LOAD:   ccff_head = buf_data[WORD_W-1];
      ST_VERIFY: ccff_head = ccff_tail;
      default:   ccff_head = 1'b0;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      buf_data  <= '0;
      buf_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            cfg_ok    <= 1'b0;
            err       <= 1'b0;
            shift_cnt <= '0;
            buf_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (load_shift) begin
            buf_data  <= buf_data << 1;
            buf_cnt   <= buf_cnt - BUF_ONE;
            shift_cnt <= shift_cnt + CNT_ONE;
          end
          if (accept) begin
            buf_data <= s_data;
            buf_cnt  <= BUF_FULL;
          end
          if (load_shift && final_bit) begin
            state     <= ST_VERIFY;
            shift_cnt <= '0;
            buf_cnt   <= '0;
          end
        end
        ST_VERIFY: begin
          if (final_bit) begin
            // Fold in this cycle's tail bit so the verdict lines up with done.
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            cfg_ok <= (crc16_step(crc_rb, ccff_tail) == crc_ld);
            err    <= (crc16_step(crc_rb, ccff_tail) != crc_ld);
          end else begin
            shift_cnt <= shift_cnt + CNT_ONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  ccff_crc16 u_crc_ld (
    .clk    (prog_clk),
    .resetn (reset),
    .clr    (crc_clr),
    .en     (load_shift),
    .bit_in (buf_data[WORD_W-1]),
    .crc    (crc_ld)
  );

  ccff_crc16 u_crc_rb (
    .clk    (prog_clk),
    .resetn (reset),
    .clr    (crc_clr),
    .en     (verify_shift),
    .bit_in (ccff_tail),
    .crc    (crc_rb)
  );

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - directed vector bench for ccff_loader with behavioural 16- and 12-bit chains
module tb_ccff_loader;

  logic       prog_clk = 1'b0;
  logic       reset;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       stuck;
  logic       sel;

  logic s_ready_a, head_a, tail_a, prog_en_a, busy_a, done_a, ok_a, err_a;
  logic s_ready_b, head_b, tail_b, prog_en_b, busy_b, done_b, ok_b, err_b;

  logic [15:0] chain_a = '0;
  logic [11:0] chain_b = '0;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
    .prog_clk (prog_clk), .reset (reset), .start (start), .s_valid (s_valid),
    .s_data (s_data), .s_ready (s_ready_a), .ccff_head (head_a), .ccff_tail (tail_a),
    .prog_en (prog_en_a), .busy (busy_a), .done (done_a), .cfg_ok (ok_a), .err (err_a)
  );

  ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
    .prog_clk (prog_clk), .reset (reset), .start (start), .s_valid (s_valid),
    .s_data (s_data), .s_ready (s_ready_b), .ccff_head (head_b), .ccff_tail (tail_b),
    .prog_en (prog_en_b), .busy (busy_b), .done (done_b), .cfg_ok (ok_b), .err (err_b)
  );

  // Fabric chain models: head enters bit 0, tail is the oldest bit; stuck pins the tail FF at 0.
  always @(posedge prog_clk) if (prog_en_a) chain_a <= {chain_a[14:0], head_a};
  always @(posedge prog_clk) if (prog_en_b) chain_b <= {chain_b[10:0], head_b};
  assign tail_a = stuck ? 1'b0 : chain_a[15];
  assign tail_b = stuck ? 1'b0 : chain_b[11];

  logic        v_ready, v_prog_en, v_busy, v_done, v_ok, v_err;
  logic [15:0] v_chain;
  assign v_ready   = sel ? s_ready_b : s_ready_a;
  assign v_prog_en = sel ? prog_en_b : prog_en_a;
  assign v_busy    = sel ? busy_b    : busy_a;
  assign v_done    = sel ? done_b    : done_a;
  assign v_ok      = sel ? ok_b      : ok_a;
  assign v_err     = sel ? err_b     : err_a;
  assign v_chain   = sel ? {4'b0000, chain_b} : chain_a;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        b;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          gap;
    logic        stuck;
    logic        poke;
    logic [15:0] exp_ld;
    logic [15:0] exp_fin;
    logic        exp_ok;
    int          exp_stalls;
  } vec_t;

  vec_t vecs [6];

  task automatic apply_reset();
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; stuck = 1'b0;
    @(posedge prog_clk); #1;
    @(posedge prog_clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n, sent, hold, shifts, stalls, ready_after;
    logic        snapped, seen_done, acc;
    logic [15:0] snap;
    string       tag;
    tag = $sformatf("v%0d", idx);
    n = v.b ? 12 : 16;
    apply_reset();
    sel = v.b;
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    sent = 0; hold = 0; shifts = 0; stalls = 0; ready_after = 0;
    snapped = 1'b0; seen_done = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      if (shifts == n && !snapped) begin
        snap    = v_chain;
        snapped = 1'b1;
        stuck   = v.stuck;
      end
      s_valid = (sent < 2) && (hold == 0);
      s_data  = (sent == 0) ? v.w0 : v.w1;
      start   = v.poke && (cyc == 4);
      if (v_prog_en) shifts++;
      if (v_busy && !v_prog_en) stalls++;
      if (sent == 2 && v_ready) ready_after++;
      acc = s_valid && v_ready;
      if (v_done) begin
        seen_done = 1'b1;
      end else begin
        @(posedge prog_clk);
        if (acc) begin
          sent++;
          if (sent == 1) hold = 7 + v.gap;
        end else if (hold > 0) begin
          hold--;
        end
        #1;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_chain_loaded"}, snap, v.exp_ld);
    check({tag, "_chain_final"}, v_chain, v.exp_fin);
    check({tag, "_prog_en_total"}, shifts, 2 * n);
    check({tag, "_stall_cycles"}, stalls, v.exp_stalls);
    check({tag, "_ready_after_last"}, ready_after, 0);
    check({tag, "_cfg_ok"}, v_ok, v.exp_ok);
    check({tag, "_err"}, v_err, !v.exp_ok);
    @(posedge prog_clk); #1;
    check({tag, "_done_one_cycle"}, {v_done, v_busy, v_prog_en}, 3'b000);
    check({tag, "_result_held"}, {v_ok, v_err}, {v.exp_ok, !v.exp_ok});
    stuck = 1'b0;
  endtask

  initial begin
    int n;
    sel = 1'b0;
    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 16'hA53C, 16'hA53C, 1'b1, 1};
    vecs[1] = '{1'b0, 8'hA5, 8'h3C, 3, 1'b0, 1'b0, 16'hA53C, 16'hA53C, 1'b1, 4};
    vecs[2] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b1, 1'b0, 16'hA53C, 16'h0000, 1'b0, 1};
    vecs[3] = '{1'b1, 8'hFF, 8'hF0, 0, 1'b0, 1'b0, 16'h0FFF, 16'h0FFF, 1'b1, 1};
    vecs[4] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 16'hA53C, 16'hA53C, 1'b1, 1};
    vecs[5] = '{1'b0, 8'h5A, 8'hC3, 1, 1'b0, 1'b0, 16'h5AC3, 16'h5AC3, 1'b1, 2};

    apply_reset();
    check("reset_outputs_a", {s_ready_a, head_a, prog_en_a, busy_a, done_a, ok_a, err_a}, 7'b0);
    check("reset_outputs_b", {s_ready_b, head_b, prog_en_b, busy_b, done_b, ok_b, err_b}, 7'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort a load after five shifts, hold start high through reset, then reload.
    apply_reset();
    sel = 1'b0;
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    check("midload_busy", busy_a, 1);
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (prog_en_a) n++;
      @(posedge prog_clk); #1;
    end
    check("midload_shifts", n, 5);
    reset = 1'b0; start = 1'b1; s_valid = 1'b0;
    @(posedge prog_clk); #1;
    check("abort_outputs", {s_ready_a, head_a, prog_en_a, busy_a, done_a, ok_a, err_a}, 7'b0);
    @(posedge prog_clk); #1;
    check("abort_start_ignored", {s_ready_a, prog_en_a, busy_a}, 3'b000);
    reset = 1'b1; start = 1'b0;
    run_vec(vecs[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
